axi_clint: RTL and testbench

//  AXI4-Lite responder implementing a CLINT-style core-local interruptor:

---
 rtl/clint_pkg.sv | 61 ++++++
 rtl/clint_timer.sv | 100 ++++++++++
 rtl/axi_clint.sv | 214 +++++++++++++++++++++
 tb/tb_axi_clint.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT: register offsets, response codes,
// register selector and helpers for address decode and byte-masked writes.
package clint_pkg;

   localparam logic [15:0] OFF_MSIP        = 16'h0000;
   localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      REG_NONE    = 3'd0,
      REG_MSIP    = 3'd1,
      REG_CMP_LO  = 3'd2,
      REG_CMP_HI  = 3'd3,
      REG_TIME_LO = 3'd4,
      REG_TIME_HI = 3'd5
   } reg_sel_e;

   // Map a byte address to a register; addr[1:0] is ignored.
   function automatic reg_sel_e clint_decode(input logic [31:0] addr,
                                             input logic [15:0] base_hi);
      reg_sel_e sel;
      sel = REG_NONE;
      if (addr[31:16] == base_hi) begin
         case ({addr[15:2], 2'b00})
            OFF_MSIP:        sel = REG_MSIP;
            OFF_MTIMECMP_LO: sel = REG_CMP_LO;
            OFF_MTIMECMP_HI: sel = REG_CMP_HI;
            OFF_MTIME_LO:    sel = REG_TIME_LO;
            OFF_MTIME_HI:    sel = REG_TIME_HI;
            default:         sel = REG_NONE;
         endcase
      end else begin
         sel = REG_NONE;
      end
      return sel;
   endfunction

   // Replace the bytes of old_v selected by strb with the bytes of new_v.
   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_v[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_v[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_timer.sv
// Timer core of the CLINT: prescaler, 64-bit mtime, 64-bit mtimecmp and the
// registered comparison that drives the timer interrupt. A software write to
// either half of mtime suppresses the tick increment on that edge.
module clint_timer
   import clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        mtime_lo_we_i,
   input  logic        mtime_hi_we_i,
   input  logic        cmp_lo_we_i,
   input  logic        cmp_hi_we_i,
   output logic [63:0] mtime_o,
   output logic [63:0] mtimecmp_o,
   output logic        timer_int_o
);

   logic [31:0] presc_q, presc_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] cmp_q, cmp_d;
   logic        timer_int_q, timer_int_d;
   logic        tick_s;

   assign tick_s = (presc_q == (TICK_DIV - 32'd1));

   // Prescaler wraps after TICK_DIV cycles.
   always_comb begin
      presc_d = presc_q;
      if (tick_s) begin
         presc_d = 32'd0;
      end else begin
         presc_d = presc_q + 32'd1;
      end
   end

   // mtime: software write wins over the tick on the same edge.
   always_comb begin
      mtime_d = mtime_q;
      if (mtime_lo_we_i || mtime_hi_we_i) begin
         if (mtime_lo_we_i) begin
            mtime_d[31:0] = strb_merge(mtime_q[31:0], wdata_i, wstrb_i);
         end else begin
            mtime_d[31:0] = mtime_q[31:0];
         end
         if (mtime_hi_we_i) begin
            mtime_d[63:32] = strb_merge(mtime_q[63:32], wdata_i, wstrb_i);
         end else begin
            mtime_d[63:32] = mtime_q[63:32];
         end
      end else if (tick_s) begin
         mtime_d = mtime_q + 64'd1;
      end else begin
         mtime_d = mtime_q;
      end
   end

   // mtimecmp halves are updated independently by byte-masked writes.
   always_comb begin
      cmp_d = cmp_q;
      if (cmp_lo_we_i) begin
         cmp_d[31:0] = strb_merge(cmp_q[31:0], wdata_i, wstrb_i);
      end else begin
         cmp_d[31:0] = cmp_q[31:0];
      end
      if (cmp_hi_we_i) begin
         cmp_d[63:32] = strb_merge(cmp_q[63:32], wdata_i, wstrb_i);
      end else begin
         cmp_d[63:32] = cmp_q[63:32];
      end
   end

   // Interrupt reflects the already-updated registers, one cycle behind them.
   always_comb begin
      timer_int_d = (mtime_q >= cmp_q);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q     <= 32'd0;
         mtime_q     <= 64'd0;
         cmp_q       <= 64'hFFFF_FFFF_FFFF_FFFF;
         timer_int_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         mtime_q     <= mtime_d;
         cmp_q       <= cmp_d;
         timer_int_q <= timer_int_d;
      end
   end

   assign mtime_o     = mtime_q;
   assign mtimecmp_o  = cmp_q;
   assign timer_int_o = timer_int_q;

endmodule

// File: rtl/axi_clint.sv
// AXI4-Lite responder for the core-local interruptor. Holds the read channel,
// the independent AW/W holding registers, the write response, msip, and the
// address decode; the counter/compare logic lives in clint_timer.
module axi_clint
   import clint_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [2:0]  arprot,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   input  logic [31:0] awaddr,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   output logic        timer_int,
   output logic        soft_int
);

   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   resp_e       rresp_q, rresp_d;
   logic        aw_held_q, aw_held_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic        w_held_q, w_held_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        bvalid_q, bvalid_d;
   resp_e       bresp_q, bresp_d;
   logic        msip_q, msip_d;

   logic        ar_hs_s, aw_hs_s, w_hs_s, commit_s;
   reg_sel_e    rd_sel_s, wr_sel_s;
   logic [31:0] rd_data_s;
   resp_e       rd_resp_s;
   logic [31:0] wr_addr_s, wr_data_s;
   logic [3:0]  wr_strb_s;
   logic [63:0] mtime_s, mtimecmp_s;
   logic        timer_int_s;
   logic        unused_s;

   assign unused_s = ^{arprot, awprot};

   assign arready = ~rvalid_q;
   assign awready = ~aw_held_q & ~bvalid_q;
   assign wready  = ~w_held_q & ~bvalid_q;

   assign ar_hs_s = arvalid & arready;
   assign aw_hs_s = awvalid & awready;
   assign w_hs_s  = wvalid & wready;

   // Address and data of the write come from the holding regs if already
   // captured, otherwise from the bus on the handshaking cycle.
   assign wr_addr_s = aw_held_q ? awaddr_q : awaddr;
   assign wr_data_s = w_held_q ? wdata_q : wdata;
   assign wr_strb_s = w_held_q ? wstrb_q : wstrb;
   assign commit_s  = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s) & ~bvalid_q;

   assign rd_sel_s = clint_decode(araddr, BASE_ADDR[31:16]);
   assign wr_sel_s = clint_decode(wr_addr_s, BASE_ADDR[31:16]);

   // Read mux over the current (pre-update) register values.
   always_comb begin
      rd_data_s = 32'd0;
      rd_resp_s = RESP_OKAY;
      case (rd_sel_s)
         REG_MSIP:    rd_data_s = {31'd0, msip_q};
         REG_CMP_LO:  rd_data_s = mtimecmp_s[31:0];
         REG_CMP_HI:  rd_data_s = mtimecmp_s[63:32];
         REG_TIME_LO: rd_data_s = mtime_s[31:0];
         REG_TIME_HI: rd_data_s = mtime_s[63:32];
         default: begin
            rd_data_s = 32'd0;
            rd_resp_s = RESP_DECERR;
         end
      endcase
   end

   // Read channel: capture on AR handshake, hold until R handshake.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs_s) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_data_s;
         rresp_d  = rd_resp_s;
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
   end

   // Write holding regs fill on their own handshake and empty on commit.
   always_comb begin
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      if (commit_s) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end else begin
         if (aw_hs_s) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
         end else begin
            aw_held_d = aw_held_q;
         end
         if (w_hs_s) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
         end else begin
            w_held_d = w_held_q;
         end
      end
   end

   // Write response raised on commit, dropped on B handshake.
   always_comb begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      if (commit_s) begin
         bvalid_d = 1'b1;
         bresp_d  = (wr_sel_s == REG_NONE) ? RESP_DECERR : RESP_OKAY;
      end else if (bvalid_q && bready) begin
         bvalid_d = 1'b0;
      end else begin
         bvalid_d = bvalid_q;
      end
   end

   // msip keeps only bit 0; the remaining bits read as zero.
   always_comb begin
      msip_d = msip_q;
      if (commit_s && (wr_sel_s == REG_MSIP) && wr_strb_s[0]) begin
         msip_d = wr_data_s[0];
      end else begin
         msip_d = msip_q;
      end
   end

   // AXI-side state registers with asynchronous reset.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= RESP_OKAY;
         aw_held_q <= 1'b0;
         awaddr_q  <= 32'd0;
         w_held_q  <= 1'b0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         msip_q    <= 1'b0;
      end else begin
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         msip_q    <= msip_d;
      end
   end

   clint_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk_i         (aclk),
      .rst_ni        (areset),
      .wdata_i       (wr_data_s),
      .wstrb_i       (wr_strb_s),
      .mtime_lo_we_i (commit_s && (wr_sel_s == REG_TIME_LO)),
      .mtime_hi_we_i (commit_s && (wr_sel_s == REG_TIME_HI)),
      .cmp_lo_we_i   (commit_s && (wr_sel_s == REG_CMP_LO)),
      .cmp_hi_we_i   (commit_s && (wr_sel_s == REG_CMP_HI)),
      .mtime_o       (mtime_s),
      .mtimecmp_o    (mtimecmp_s),
      .timer_int_o   (timer_int_s)
   );

   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign rresp     = rresp_q;
   assign bvalid    = bvalid_q;
   assign bresp     = bresp_q;
   assign timer_int = timer_int_s;
   assign soft_int  = msip_q;

endmodule

// File: tb/tb_axi_clint.sv
// Bench for axi_clint: a transaction-level model (queues of accepted AW/W,
// pending R/B responses, plain 64-bit counters) checked against the DUT on
// every negedge, plus directed scenarios with hand-computed literals.
module tb_axi_clint;

   localparam int unsigned TICK_DIV = 1;

   logic        aclk = 1'b0;
   logic        areset = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic [31:0] araddr = 32'd0;
   logic [31:0] awaddr = 32'd0, wdata = 32'd0;
   logic [3:0]  wstrb = 4'd0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic        arready, rvalid, awready, wready, bvalid, timer_int, soft_int;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   always #5 aclk = ~aclk;

   axi_clint #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(TICK_DIV)) dut (
      .aclk(aclk), .areset(areset),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'd0),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .awaddr(awaddr), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .timer_int(timer_int), .soft_int(soft_int)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0] m_time = 64'd0;
   logic [63:0] m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
   logic        m_msip = 1'b0;
   logic        m_tint = 1'b0;
   int unsigned m_psc  = 0;
   logic [31:0] awq[$];
   logic [35:0] wq[$];
   logic [33:0] rq[$];
   logic [1:0]  bq[$];

   function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
      return r;
   endfunction

   function automatic logic [33:0] m_read(input logic [31:0] a);
      if (a[31:16] != 16'h0200) return {2'b11, 32'd0};
      case ({a[15:2], 2'b00})
         16'h0000: return {2'b00, 31'd0, m_msip};
         16'h4000: return {2'b00, m_cmp[31:0]};
         16'h4004: return {2'b00, m_cmp[63:32]};
         16'hBFF8: return {2'b00, m_time[31:0]};
         16'hBFFC: return {2'b00, m_time[63:32]};
         default:  return {2'b11, 32'd0};
      endcase
   endfunction

   always @(posedge aclk or negedge areset) begin : model
      logic [63:0] t_next;
      logic [31:0] a;
      logic [35:0] w;
      logic [1:0]  resp;
      logic        tint_next, tick;
      if (!areset) begin
         m_time = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0;
         m_tint = 1'b0; m_psc = 0;
         awq.delete(); wq.delete(); rq.delete(); bq.delete();
      end else begin
         if (rvalid && rready && rq.size() > 0) void'(rq.pop_front());
         if (arvalid && arready) rq.push_back(m_read(araddr));
         if (bvalid && bready && bq.size() > 0) void'(bq.pop_front());
         if (awvalid && awready) awq.push_back(awaddr);
         if (wvalid && wready) wq.push_back({wstrb, wdata});
         tint_next = (m_time >= m_cmp);
         tick = (m_psc == TICK_DIV - 1);
         m_psc = tick ? 0 : m_psc + 1;
         t_next = tick ? m_time + 64'd1 : m_time;
         if (awq.size() > 0 && wq.size() > 0) begin
            a = awq.pop_front();
            w = wq.pop_front();
            resp = 2'b00;
            if (a[31:16] != 16'h0200) resp = 2'b11;
            else case ({a[15:2], 2'b00})
               16'h0000: if (w[32]) m_msip = w[0];
               16'h4000: m_cmp[31:0]  = m_merge(m_cmp[31:0], w[31:0], w[35:32]);
               16'h4004: m_cmp[63:32] = m_merge(m_cmp[63:32], w[31:0], w[35:32]);
               16'hBFF8: t_next = {m_time[63:32], m_merge(m_time[31:0], w[31:0], w[35:32])};
               16'hBFFC: t_next = {m_merge(m_time[63:32], w[31:0], w[35:32]), m_time[31:0]};
               default:  resp = 2'b11;
            endcase
            bq.push_back(resp);
         end
         m_time = t_next;
         m_tint = tint_next;
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge aclk) begin
      check("arready", arready, rq.size() == 0);
      check("rvalid", rvalid, rq.size() != 0);
      if (rq.size() != 0) begin
         check("rdata", rdata, rq[0][31:0]);
         check("rresp", rresp, rq[0][33:32]);
      end
      check("bvalid", bvalid, bq.size() != 0);
      if (bq.size() != 0) check("bresp", bresp, bq[0]);
      check("awready", awready, (awq.size() == 0) && (bq.size() == 0));
      check("wready", wready, (wq.size() == 0) && (bq.size() == 0));
      check("timer_int", timer_int, m_tint);
      check("soft_int", soft_int, m_msip);
   end

   // ---------------- bus tasks ----------------
   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      @(negedge aclk);
      arvalid = 1'b1; araddr = addr; n = 0;
      do begin @(posedge aclk); n++; end while (!arready && n < 50);
      if (n >= 50) check("ar_timeout", 64'd0, 64'd1);
      @(negedge aclk);
      arvalid = 1'b0; n = 0;
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) check("r_timeout", 64'd0, 64'd1);
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      int n;
      bit aw_ok, w_ok;
      @(negedge aclk);
      awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
      aw_ok = 1'b0; w_ok = 1'b0; n = 0;
      while (!(aw_ok && w_ok) && n < 50) begin
         @(posedge aclk);
         if (awvalid && awready) aw_ok = 1'b1;
         if (wvalid && wready) w_ok = 1'b1;
         n++;
         @(negedge aclk);
         if (aw_ok) awvalid = 1'b0;
         if (w_ok) wvalid = 1'b0;
      end
      if (n >= 50) check("aw_w_timeout", 64'd0, 64'd1);
      n = 0;
      while (!bvalid && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) check("b_timeout", 64'd0, 64'd1);
      resp = bresp;
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      logic [31:0] d;
      logic [1:0]  r;
      int n;

      // 1: reset values, then read mtime lo with AR handshake on edge 5
      repeat (3) @(negedge aclk);
      check("rst_rvalid", rvalid, 64'd0);
      check("rst_bvalid", bvalid, 64'd0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_arready", arready, 64'd1);
      check("rst_timer_int", timer_int, 64'd0);
      areset = 1'b1;
      repeat (4) @(posedge aclk);
      do_read(32'h0200_BFF8, d, r);
      check("t1_mtime_at_edge5", d, 64'd4);
      check("t1_rresp", r, 64'd0);
      check("t1_timer_int", timer_int, 64'd0);

      // 2: mtimecmp = 10, interrupt rises, then cleared by hi = 1
      do_write(32'h0200_4000, 32'd10, 4'hF, r);
      check("t2_bresp_lo", r, 64'd0);
      do_write(32'h0200_BFF8, 32'd0, 4'hF, r);
      do_write(32'h0200_4004, 32'd0, 4'hF, r);
      check("t2_bresp_hi", r, 64'd0);
      n = 0;
      while (!timer_int && n < 40) begin @(negedge aclk); n++; end
      check("t2_timer_int_rises", timer_int, 64'd1);
      do_write(32'h0200_4004, 32'd1, 4'hF, r);
      check("t2_timer_int_falls", timer_int, 64'd0);

      // 3: W three cycles ahead of AW, then B held with bready low
      @(negedge aclk);
      wvalid = 1'b1; wdata = 32'h0000_1000; wstrb = 4'hF;
      @(negedge aclk);
      wvalid = 1'b0;
      check("t3_wready_after_w", wready, 64'd0);
      check("t3_awready_open", awready, 64'd1);
      repeat (2) @(negedge aclk);
      check("t3_wready_still_low", wready, 64'd0);
      awvalid = 1'b1; awaddr = 32'h0200_4000;
      @(negedge aclk);
      awvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t3_bvalid_held", bvalid, 64'd1);
         check("t3_awready_blocked", awready, 64'd0);
         check("t3_wready_blocked", wready, 64'd0);
         @(negedge aclk);
      end
      check("t3_bresp", bresp, 64'd0);
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      check("t3_bvalid_cleared", bvalid, 64'd0);

      // 4: mtime carry lo -> hi, then byte-1-only write
      do_write(32'h0200_BFFC, 32'd0, 4'hF, r);
      do_write(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, r);
      do_read(32'h0200_BFFC, d, r);
      check("t4_mtime_hi_carry", d, 64'd1);
      do_write(32'h0200_BFF8, 32'h0000_AB00, 4'b0010, r);
      do_read(32'h0200_BFF8, d, r);
      check("t4_byte1_only", {40'd0, d[31:8]}, 64'h0000_00AB);
      do_read(32'h0200_BFFC, d, r);
      check("t4_hi_unchanged", d, 64'd1);

      // 5: decode errors and msip
      do_read(32'h0200_0008, d, r);
      check("t5_rresp_decerr", r, 64'd3);
      check("t5_rdata_zero", d, 64'd0);
      do_write(32'h0200_1234, 32'hFFFF_FFFF, 4'hF, r);
      check("t5_bresp_decerr", r, 64'd3);
      do_read(32'h0300_BFF8, d, r);
      check("t5_outside_window", r, 64'd3);
      do_write(32'h0200_0000, 32'd1, 4'hF, r);
      check("t5_soft_int", soft_int, 64'd1);
      do_write(32'h0200_0000, 32'd0, 4'b1110, r);
      do_read(32'h0200_0000, d, r);
      check("t5_msip_read", d, 64'd1);

      // 6: asynchronous reset while a read response is pending
      @(negedge aclk);
      arvalid = 1'b1; araddr = 32'h0200_4004;
      @(negedge aclk);
      arvalid = 1'b0;
      check("t6_rvalid_pending", rvalid, 64'd1);
      #2 areset = 1'b0;
      #1;
      check("t6_rvalid_async", rvalid, 64'd0);
      check("t6_soft_int_async", soft_int, 64'd0);
      @(negedge aclk);
      areset = 1'b1;
      check("t6_arready", arready, 64'd1);
      do_read(32'h0200_4004, d, r);
      check("t6_cmp_hi", d, 64'hFFFF_FFFF);
      do_read(32'h0200_4000, d, r);
      check("t6_cmp_lo", d, 64'hFFFF_FFFF);
      do_read(32'h0200_BFFC, d, r);
      check("t6_mtime_hi", d, 64'd0);

      repeat (3) @(negedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
